bp_resolve_unit: RTL
====================

Name: bp_resolve_unit

Overview:
- Resolution/writer side of the gshare predictor; the predictor is the fetch-side reader.
- Holds in-flight fetch predictions in a small ordered queue, tagged with pc, predicted direction/target, GPT index and 2-bit counter read.
- Compares each queued prediction with the actual branch outcome from EX. Drives the GPT write (index, new saturating counter), the mispredict/redirect to fetch, and the wrong-path queue flush.
- Sits between the IF-stage predictor lookup and the EX-stage branch unit.

Parameters:
DEPTH, 4, number of in-flight prediction entries (power of 2, ≥2)
IDX_W, 10, GPT index width
CNT_W, 16, statistics counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
push_valid  input  1  IF: conditional branch/jump fetched, push entry
push_pc  input  32  fetched pc
push_pred_taken  input  1  predicted direction (counter MSB)
push_ctr  input  2  GPT counter value read at fetch
push_index  input  IDX_W  GPT index used at fetch
push_target  input  32  predicted target (BTB/decoded)
q_full  output  1  queue holds DEPTH entries
q_empty  output  1  queue holds 0 entries
res_valid  input  1  EX: oldest branch resolved this cycle
res_pc  input  32  pc of resolving branch
res_taken  input  1  actual direction
res_target  input  32  actual taken target
upd_valid  output  1  GPT write strobe, 1-cycle pulse
upd_index  output  IDX_W  GPT write index
upd_ctr  output  2  new counter value
upd_taken  output  1  actual outcome, for GBHR shift
mispredict  output  1  1-cycle pulse: flush younger stages
redirect_pc  output  32  correct next pc, valid with mispredict
err_order  output  1  1-cycle pulse: resolve with empty queue or pc mismatch
overflow  output  1  sticky: push dropped while full
br_count  output  CNT_W  resolved branches, saturating
mp_count  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset: queue empty (q_empty=1, q_full=0); all outputs 0; rst mid-operation discards all entries immediately.
- Queue: circular buffer, rd/wr pointers plus occupancy count of width log2(DEPTH)+1. Push writes at wr_ptr. Pop on res_valid takes head. Pointers wrap modulo DEPTH.
- Push while full without a concurrent pop is dropped and sets overflow. Push while full with a concurrent non-flushing pop is accepted; occupancy stays unchanged.
- Resolve (res_valid=1, queue non-empty, head.pc==res_pc): outputs are registered and appear one cycle after the res_valid edge.
  - br_count increments.
  - mispredict = (head.pred_taken != res_taken) OR (res_taken AND head.target != res_target).
  - redirect_pc = res_taken ? res_target : res_pc+4, with 32-bit wrap.
  - upd_valid=1 only when res_pc[1:0]==2'b00. upd_index=head.index. upd_taken=res_taken.
  - upd_ctr: on taken, saturating increment (3 stays 3); on not taken, saturating decrement (0 stays 0).
- Mispredict:
  - Head pops and all remaining entries are flushed at the same edge.
  - A push in the same cycle is discarded and does not set overflow.
  - mp_count increments.
- Error cases, both producing an err_order pulse, mispredict=1, redirect_pc as above, queue flushed, no GPT write, no counter increments:
  - res_valid with the queue empty.
  - Head pc mismatch.
- Statistics counters saturate at all-ones and never wrap.
- Combinational inputs go only to registers; no combinational input-to-output path.

Decomposition:
- Shared bp_pkg holds IDX_W, the 2-bit counter encodings (SNT=0, WNT=1, WT=2, ST=3), the queue entry struct {pc, pred_taken, ctr, index, target}, and a sat_update counter function used by both predictor and resolver.
- One sub-module, bp_inflight_fifo: the parameterised queue with a flush input, returning the head entry.

Test Plan:
- Push pc=0x100, pred_taken=1, ctr=2, idx=0x040, target=0x200; resolve taken, target 0x200 → next cycle upd_valid=1, upd_index=0x040, upd_ctr=3, mispredict=0, br_count=1.
- Push ctr=3/taken, resolve not taken at pc=0x104 → mispredict=1, redirect_pc=0x108, upd_ctr=2, mp_count=1.
- Push 3 entries, first mispredicts while a 4th push arrives → q_empty=1 after the edge, 4th push discarded, overflow=0.
- Fill DEPTH=4, push again with no pop → overflow=1, q_full=1. Push+pop in the same cycle while full → accepted, q_full stays 1.
- res_valid with the queue empty → err_order=1, upd_valid=0, br_count unchanged. Head pc 0x100 vs res_pc 0x104 → err_order=1, queue flushed.
- ctr=0 resolved not taken → upd_ctr=0. res_pc=0x102 → no upd_valid, counters still update. Assert rst mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared gshare definitions: GPT index width, counter encodings, the in-flight
// entry layout and the 2-bit saturating counter update used by reader and writer.
package bp_pkg;

  localparam int unsigned IDX_W = 10;

  typedef enum logic [1:0] {
    CtrSnt = 2'd0,
    CtrWnt = 2'd1,
    CtrWt  = 2'd2,
    CtrSt  = 2'd3
  } ctr_e;

  typedef struct packed {
    logic [31:0]      pc;
    logic             pred_taken;
    logic [1:0]       ctr;
    logic [IDX_W-1:0] index;
    logic [31:0]      target;
  } entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == CtrSt) ? ctr : ctr + 2'd1;
    end else begin
      res = (ctr == CtrSnt) ? ctr : ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_resolve_unit_if.sv
// Fetch-push, EX-resolve and GPT-update signals between the resolver and its neighbours.
interface bp_resolve_unit_if #(
  parameter int unsigned CNT_W = 16
);
  import bp_pkg::*;

  logic             push_valid;
  logic [31:0]      push_pc;
  logic             push_pred_taken;
  logic [1:0]       push_ctr;
  logic [IDX_W-1:0] push_index;
  logic [31:0]      push_target;
  logic             q_full;
  logic             q_empty;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic [1:0]       upd_ctr;
  logic             upd_taken;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic             err_order;
  logic             overflow;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output push_valid, push_pc, push_pred_taken, push_ctr, push_index, push_target,
    output res_valid, res_pc, res_taken, res_target,
    input  q_full, q_empty, upd_valid, upd_index, upd_ctr, upd_taken,
    input  mispredict, redirect_pc, err_order, overflow, br_count, mp_count
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_ctr, push_index, push_target,
    input  res_valid, res_pc, res_taken, res_target,
    output q_full, q_empty, upd_valid, upd_index, upd_ctr, upd_taken,
    output mispredict, redirect_pc, err_order, overflow, br_count, mp_count
  );

endinterface

// File: rtl/bp_inflight_fifo.sv
// Ordered queue of in-flight predictions; flush empties it and wins over push/pop.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  input  logic   flush,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  entry_t          mem_q [DEPTH];
  logic            push_ok, pop_ok;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && !flush && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/bp_resolve_unit.sv
// gshare resolver: matches EX outcomes against queued fetch predictions and
// produces the registered GPT update, redirect and statistics.
module bp_resolve_unit
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  bp_resolve_unit_if.slave bus
);

  entry_t head, push_entry;
  logic   full, empty;
  logic   hit, mp_raw, flush, pop, do_upd;

  logic             upd_valid_q, upd_taken_q, mispredict_q, err_order_q, overflow_q;
  logic [IDX_W-1:0] upd_index_q;
  logic [1:0]       upd_ctr_q;
  logic [31:0]      redirect_pc_q, redirect_calc;
  logic [CNT_W-1:0] br_count_q, mp_count_q;

  assign push_entry = '{pc:         bus.push_pc,
                        pred_taken: bus.push_pred_taken,
                        ctr:        bus.push_ctr,
                        index:      bus.push_index,
                        target:     bus.push_target};

  assign hit    = bus.res_valid && !empty && (head.pc == bus.res_pc);
  assign mp_raw = (head.pred_taken != bus.res_taken) ||
                  (bus.res_taken && (head.target != bus.res_target));
  // Empty-queue and pc-mismatch resolves are treated as mispredicts without a GPT write.
  assign flush  = bus.res_valid && (!hit || mp_raw);
  assign pop    = bus.res_valid && !empty;
  assign do_upd = hit && (bus.res_pc[1:0] == 2'b00);

  assign redirect_calc = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;

  bp_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.push_valid),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_ctr_q     <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      err_order_q   <= 1'b0;
      overflow_q    <= 1'b0;
      br_count_q    <= '0;
      mp_count_q    <= '0;
    end else begin
      upd_valid_q   <= do_upd;
      upd_index_q   <= hit ? head.index : '0;
      upd_ctr_q     <= hit ? sat_update(head.ctr, bus.res_taken) : 2'b00;
      upd_taken_q   <= hit && bus.res_taken;
      mispredict_q  <= flush;
      redirect_pc_q <= flush ? redirect_calc : '0;
      err_order_q   <= bus.res_valid && !hit;
      if (bus.push_valid && full && !pop) overflow_q <= 1'b1;
      if (hit && (br_count_q != '1)) br_count_q <= br_count_q + CNT_W'(1);
      if (hit && mp_raw && (mp_count_q != '1)) mp_count_q <= mp_count_q + CNT_W'(1);
    end
  end

  assign bus.q_full      = full;
  assign bus.q_empty     = empty;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_index   = upd_index_q;
  assign bus.upd_ctr     = upd_ctr_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.err_order   = err_order_q;
  assign bus.overflow    = overflow_q;
  assign bus.br_count    = br_count_q;
  assign bus.mp_count    = mp_count_q;

endmodule
